// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, N data bits MSB first, stop bit, with a valid/ready output register.
// Define SERIAL_FRAME_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module serial_frame_rx #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         BitEn,
  input  logic         Sin,
  input  logic         Ready,
  output logic [N-1:0] Dout,
  output logic         Valid,
  output logic         FrameErr,
  output logic         Overrun,
  output logic         Busy
);

  localparam int CW = $clog2(N);

`ifdef SERIAL_FRAME_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t        state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic [N-1:0]  sh, shNext;
  logic [N-1:0]  doutNext;
  logic          validNext, frameErrNext, overrunNext;
  logic          badFrame;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic          parErr, parErrNext;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      Dout     <= '0;
      Valid    <= 1'b0;
      FrameErr <= 1'b0;
      Overrun  <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      parErr   <= 1'b0;
`endif
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      sh       <= shNext;
      Dout     <= doutNext;
      Valid    <= validNext;
      FrameErr <= frameErrNext;
      Overrun  <= overrunNext;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      parErr   <= parErrNext;
`endif
    end
  end

  // Handshake and pulse defaults apply on every edge; frame progress only on BitEn edges.
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    shNext       = sh;
    doutNext     = Dout;
    validNext    = Valid && !Ready;
    frameErrNext = 1'b0;
    overrunNext  = 1'b0;
    badFrame     = !Sin;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    parErrNext   = parErr;
    badFrame     = badFrame || parErr;
`endif
    case (state)
      IDLE: begin
        if (BitEn && !Sin) begin
          stateNext = DATA;
          cntNext   = '0;
        end
      end
      DATA: begin
        if (BitEn) begin
          shNext  = {sh[N-2:0], Sin};
          cntNext = cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            cntNext = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_FRAME_RX_PARITY_EN
      PARITY: begin
        if (BitEn) begin
          parErrNext = ^{sh, Sin};
          stateNext  = STOP;
        end
      end
`endif
      STOP: begin
        // A full holding register drops the new word; a pending Ready frees it first.
        if (BitEn) begin
          stateNext = IDLE;
`ifdef SERIAL_FRAME_RX_PARITY_EN
          parErrNext = 1'b0;
`endif
          if (badFrame) begin
            frameErrNext = 1'b1;
          end else if (Valid && !Ready) begin
            overrunNext = 1'b1;
          end else begin
            doutNext  = sh;
            validNext = 1'b1;
          end
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed frames plus randomized frames against a frame-level model.
// Honours SERIAL_FRAME_RX_PARITY_EN to send and model the parity bit.
module tb_serial_frame_rx;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         BitEn;
  logic         Sin;
  logic         Ready;
  logic [N-1:0] Dout;
  logic         Valid;
  logic         FrameErr;
  logic         Overrun;
  logic         Busy;

  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] expDout;
  logic         expValid;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic         parFlip;
`endif

  serial_frame_rx #(.N(N)) dut (
    .clk(clk), .reset(reset), .BitEn(BitEn), .Sin(Sin), .Ready(Ready),
    .Dout(Dout), .Valid(Valid), .FrameErr(FrameErr), .Overrun(Overrun), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // BitEn=0 gap edges carry noise on Sin, which the receiver must ignore.
  task automatic sendBit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      BitEn = 1'b0;
      Sin   = 1'($urandom);
      tick();
    end
    BitEn = 1'b1;
    Sin   = b;
    tick();
    BitEn = 1'b0;
    Sin   = 1'b1;
  endtask

  // Sends one frame with Ready held constant and checks the outcome at the stop edge.
  task automatic applyStimulus(input logic [N-1:0] data, input logic stopBit, input logic rdy,
                               input int maxGap, input bit post);
    logic prevValid;
    logic good;
    Ready = rdy;
    sendBit(1'b0, int'($urandom_range(0, maxGap)));
    checkOutput("busy_after_start", 32'(Busy), 32'(1));
    for (int i = N - 1; i >= 0; i--) sendBit(data[i], int'($urandom_range(0, maxGap)));
`ifdef SERIAL_FRAME_RX_PARITY_EN
    sendBit((^data) ^ parFlip, int'($urandom_range(0, maxGap)));
    good = stopBit && !parFlip;
`else
    good = stopBit;
`endif
    prevValid = expValid && !rdy;
    sendBit(stopBit, int'($urandom_range(0, maxGap)));
    checkOutput("frame_err", 32'(FrameErr), 32'(!good));
    checkOutput("overrun", 32'(Overrun), 32'(good && prevValid));
    if (good && !prevValid) begin
      expValid = 1'b1;
      expDout  = data;
    end else begin
      expValid = prevValid;
    end
    checkOutput("valid_at_stop", 32'(Valid), 32'(expValid));
    checkOutput("dout_at_stop", 32'(Dout), 32'(expDout));
    checkOutput("busy_after_stop", 32'(Busy), 32'(0));
    if (post) begin
      tick();
      expValid = expValid && !rdy;
      checkOutput("frame_err_clear", 32'(FrameErr), 32'(0));
      checkOutput("overrun_clear", 32'(Overrun), 32'(0));
      checkOutput("valid_after", 32'(Valid), 32'(expValid));
      checkOutput("dout_after", 32'(Dout), 32'(expDout));
    end
  endtask

  initial begin
    reset    = 1'b1;
    BitEn    = 1'b0;
    Sin      = 1'b1;
    Ready    = 1'b0;
    expValid = 1'b0;
    expDout  = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    parFlip  = 1'b0;
`endif
    tick();
    tick();
    checkOutput("reset_dout", 32'(Dout), 32'(0));
    checkOutput("reset_valid", 32'(Valid), 32'(0));
    checkOutput("reset_frame_err", 32'(FrameErr), 32'(0));
    checkOutput("reset_overrun", 32'(Overrun), 32'(0));
    checkOutput("reset_busy", 32'(Busy), 32'(0));
    reset = 1'b0;

    // Idle line with BitEn every cycle.
    for (int i = 0; i < 20; i++) begin
      BitEn = 1'b1;
      Sin   = 1'b1;
      tick();
      checkOutput("idle_valid", 32'(Valid), 32'(0));
      checkOutput("idle_busy", 32'(Busy), 32'(0));
      checkOutput("idle_frame_err", 32'(FrameErr), 32'(0));
      checkOutput("idle_overrun", 32'(Overrun), 32'(0));
    end
    BitEn = 1'b0;

    // 0xA5 good stop, Ready=1: Valid for exactly one cycle.
    applyStimulus(8'hA5, 1'b1, 1'b1, 0, 1'b1);
    // 0xA5 bad stop: FrameErr, Dout keeps previous word.
    applyStimulus(8'hA5, 1'b0, 1'b1, 0, 1'b1);

    // Back-to-back 0x3C then 0xC3 with Ready=0: second one overruns.
    applyStimulus(8'h3C, 1'b1, 1'b0, 0, 1'b0);
    applyStimulus(8'hC3, 1'b1, 1'b0, 0, 1'b1);
    Ready = 1'b1;
    tick();
    expValid = 1'b0;
    checkOutput("drain_valid", 32'(Valid), 32'(0));
    Ready = 1'b0;

    // Reset during data bit 4 of 0xFF, then a clean 0x81.
    sendBit(1'b0, 0);
    for (int i = 0; i < 4; i++) sendBit(1'b1, 0);
    checkOutput("busy_mid_frame", 32'(Busy), 32'(1));
    reset = 1'b1;
    #1;
    checkOutput("async_reset_busy", 32'(Busy), 32'(0));
    checkOutput("async_reset_dout", 32'(Dout), 32'(0));
    expValid = 1'b0;
    expDout  = '0;
    tick();
    reset = 1'b0;
    applyStimulus(8'h81, 1'b1, 1'b0, 0, 1'b1);
    Ready = 1'b1;
    tick();
    expValid = 1'b0;
    checkOutput("drain_valid_81", 32'(Valid), 32'(0));

`ifdef SERIAL_FRAME_RX_PARITY_EN
    parFlip = 1'b0;
    applyStimulus(8'h07, 1'b1, 1'b1, 0, 1'b1);
    parFlip = 1'b1;
    applyStimulus(8'h07, 1'b1, 1'b1, 0, 1'b1);
    parFlip = 1'b0;
`endif

    // Randomized frames with gaps, mixed Ready, occasional bad stop bits and idle bits.
    for (int f = 0; f < 40; f++) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
      parFlip = ($urandom_range(0, 5) == 0);
`endif
      applyStimulus(N'($urandom), ($urandom_range(0, 7) != 0), 1'($urandom), 2, 1'($urandom));
      for (int k = 0; k < int'($urandom_range(0, 1)); k++) begin
        BitEn = 1'b1;
        Sin   = 1'b1;
        tick();
        expValid = expValid && !Ready;
        checkOutput("rand_idle_valid", 32'(Valid), 32'(expValid));
      end
      BitEn = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
